// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses PLL RESETB, qualifies lock, then releases the core reset.
// Define PLL_SEQ_LOL_COUNT_EN to build the saturating loss-of-lock counter on lol_count.
module pll_reset_sequencer #(
    parameter int HOLD_CYCLES   = 4,
    parameter int LOCK_TIMEOUT  = 16,
    parameter int STABLE_CYCLES = 8,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       locked,
    input  logic       restart,
    output logic       pll_resetb,
    output logic       sys_reset,
    output logic       ready,
    output logic       fault,
    output logic [7:0] lol_count
);

    localparam int MAX_A   = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CNT = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        RST_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retries;
    logic [RETRY_W-1:0] next_retries;
    logic               sync_meta;
    logic               locked_s;
    logic               enter;
    logic               counting;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            sync_meta <= locked;
            locked_s  <= sync_meta;
        end
    end

    // Restart overrides every other transition, so it is tested before the state decode.
    always_comb begin
        next_state   = state;
        next_retries = retries;
        if (restart) begin
            next_state   = RST_PLL;
            next_retries = '0;
        end else begin
            case (state)
                RST_PLL: begin
                    if (cnt == CNT_W'(HOLD_CYCLES - 1))
                        next_state = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        next_state = STABLE;
                    end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        next_retries = retries + RETRY_W'(1);
                        if (next_retries == RETRY_W'(MAX_RETRIES))
                            next_state = FAULT;
                        else
                            next_state = RST_PLL;
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        next_state = WAIT_LOCK;
                    end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                        next_state   = RUN;
                        next_retries = '0;
                    end
                end
                RUN: begin
                    if (!locked_s)
                        next_state = RST_PLL;
                end
                FAULT: begin
                    next_state = FAULT;
                end
                default: begin
                    next_state = RST_PLL;
                end
            endcase
        end
    end

    assign enter    = restart || (next_state != state);
    assign counting = (state == RST_PLL) || (state == WAIT_LOCK) || (state == STABLE);

    // Outputs are decoded from next_state so they register in step with the state itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= RST_PLL;
            cnt        <= '0;
            retries    <= '0;
            pll_resetb <= 1'b0;
            sys_reset  <= 1'b1;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= next_state;
            retries    <= next_retries;
            if (enter || !counting)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
            pll_resetb <= !((next_state == RST_PLL) || (next_state == FAULT));
            sys_reset  <= (next_state != RUN);
            ready      <= (next_state == RUN);
            fault      <= (next_state == FAULT);
        end
    end

`ifdef PLL_SEQ_LOL_COUNT_EN
    logic [7:0] lol_cnt;
    logic       lol_event;

    assign lol_event = (state == RUN) && !locked_s && !restart;

    always_ff @(posedge clock) begin
        if (reset)
            lol_cnt <= 8'd0;
        else if (lol_event && (lol_cnt != 8'hFF))
            lol_cnt <= lol_cnt + 8'd1;
    end

    assign lol_count = lol_cnt;
`else
    assign lol_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: a phase-level reference model queues expected outputs
// every edge and a negedge monitor compares them; lol expectations follow PLL_SEQ_LOL_COUNT_EN.
module tb_pll_reset_sequencer;

    localparam int HOLD = 4;
    localparam int TMO  = 16;
    localparam int STB  = 8;
    localparam int MAXR = 3;

    localparam int PH_RST    = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_FAULT  = 4;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       locked  = 1'b0;
    logic       restart = 1'b0;
    logic       pll_resetb;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [7:0] lol_count;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [11:0] exp_q[$];

    always #5 clock = ~clock;

    pll_reset_sequencer #(
        .HOLD_CYCLES  (HOLD),
        .LOCK_TIMEOUT (TMO),
        .STABLE_CYCLES(STB),
        .MAX_RETRIES  (MAXR)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .locked    (locked),
        .restart   (restart),
        .pll_resetb(pll_resetb),
        .sys_reset (sys_reset),
        .ready     (ready),
        .fault     (fault),
        .lol_count (lol_count)
    );

    // Reference model: phase plus cycles already spent in it; lock seen two edges late.
    int   phase    = PH_RST;
    int   in_phase = 0;
    int   tries    = 0;
    int   losses   = 0;
    logic lock_hist[$];

    always @(posedge clock) begin : model
        logic ls;
        int   nxt;
        logic [7:0] exp_lol;
        cycle = cycle + 1;
        if (reset) begin
            phase     = PH_RST;
            in_phase  = 0;
            tries     = 0;
            losses    = 0;
            lock_hist = '{1'b0, 1'b0};
        end else begin
            ls = lock_hist[lock_hist.size() - 2];
            lock_hist.push_back(locked);
            if (lock_hist.size() > 4)
                void'(lock_hist.pop_front());
            nxt = phase;
            if (restart) begin
                nxt   = PH_RST;
                tries = 0;
            end else begin
                case (phase)
                    PH_RST:    if (in_phase + 1 == HOLD) nxt = PH_WAIT;
                    PH_WAIT: begin
                        if (ls) begin
                            nxt = PH_STABLE;
                        end else if (in_phase + 1 == TMO) begin
                            tries = tries + 1;
                            nxt   = (tries >= MAXR) ? PH_FAULT : PH_RST;
                        end
                    end
                    PH_STABLE: begin
                        if (!ls) begin
                            nxt = PH_WAIT;
                        end else if (in_phase + 1 == STB) begin
                            nxt   = PH_RUN;
                            tries = 0;
                        end
                    end
                    PH_RUN: begin
                        if (!ls) begin
                            nxt    = PH_RST;
                            losses = (losses < 255) ? losses + 1 : 255;
                        end
                    end
                    default: ;
                endcase
            end
            in_phase = (restart || nxt != phase) ? 0 : in_phase + 1;
            phase    = nxt;
        end
`ifdef PLL_SEQ_LOL_COUNT_EN
        exp_lol = 8'(losses);
`else
        exp_lol = 8'd0;
`endif
        exp_q.push_back({(phase != PH_RST && phase != PH_FAULT), (phase != PH_RUN),
                         (phase == PH_RUN), (phase == PH_FAULT), exp_lol});
    end

    task automatic check_output(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s cycle %0d: got resetb=%b sys_reset=%b ready=%b fault=%b lol=%0d, want resetb=%b sys_reset=%b ready=%b fault=%b lol=%0d",
                     name, cycle, act[11], act[10], act[9], act[8], act[7:0],
                     exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    always @(negedge clock) begin : monitor
        logic [11:0] exp;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check_output("outputs", {pll_resetb, sys_reset, ready, fault, lol_count}, exp);
        end
    end

    task automatic apply_stimulus(input logic rst, input logic lck, input logic rs, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            reset   = rst;
            locked  = lck;
            restart = rs;
        end
    endtask

    initial begin
        // Power-up with lock present from the start.
        apply_stimulus(1'b1, 1'b1, 1'b0, 3);
        apply_stimulus(1'b0, 1'b1, 1'b0, 30);

        // Lock never arrives: retries exhaust into FAULT, restart recovers.
        apply_stimulus(1'b0, 1'b0, 1'b0, 90);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 10);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 30);

        // Single-cycle lock glitch at a range of points during qualification.
        for (int off = 0; off < 12; off++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 2);
            apply_stimulus(1'b0, 1'b1, 1'b0, off + 3);
            apply_stimulus(1'b0, 1'b0, 1'b0, 1);
            apply_stimulus(1'b0, 1'b1, 1'b0, 25);
        end

        // Random lock behaviour with occasional restart and reset.
        for (int seg = 0; seg < 150; seg++) begin
            logic lck;
            int   len;
            lck = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++)
                apply_stimulus(($urandom % 200) == 0, lck, ($urandom % 50) == 0, 1);
        end

        // Repeated loss of lock from RUN drives the counter into saturation.
        apply_stimulus(1'b1, 1'b1, 1'b0, 2);
        for (int ev = 0; ev < 300; ev++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 22);
            apply_stimulus(1'b0, 1'b0, 1'b0, 2);
        end
        apply_stimulus(1'b0, 1'b1, 1'b0, 25);

        // Reset and restart together while running: reset wins.
        apply_stimulus(1'b1, 1'b1, 1'b1, 1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 30);

        apply_stimulus(1'b0, 1'b1, 1'b0, 3);
        if (checks < 12) begin
            errors = errors + 1;
            $display("[TB] FAIL check_count: got %0d comparisons, want at least 12", checks);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: number of cycles pll_resetb is held low per PLL reset.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 16: number of WAIT_LOCK cycles before a retry.
REQ-003 SHALL have parameter STABLE_CYCLES, default 8: number of consecutive synced-locked cycles required before release.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: number of consecutive timeouts before FAULT.
REQ-005 SHALL have port clock, input, 1 bit: PLL reference clock and the sole clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port locked, input, 1 bit: PLL LOCK, asynchronous to clock.
REQ-008 SHALL have port restart, input, 1 bit: single-cycle request to re-sequence.
REQ-009 SHALL have port pll_resetb, output, 1 bit: drives PLL RESETB, active-low.
REQ-010 SHALL have port sys_reset, output, 1 bit: active-high reset for the downstream core.
REQ-011 SHALL have port ready, output, 1 bit: high only in RUN.
REQ-012 SHALL have port fault, output, 1 bit: high only in FAULT.
REQ-013 SHALL have port lol_count, output, 8 bits: saturating count of loss-of-lock events.

Function
REQ-014 SHALL pass locked through a 2-flop synchronizer (locked_s); all decisions use locked_s, giving 2-cycle input latency.
REQ-015 SHALL implement states RST_PLL, WAIT_LOCK, STABLE, RUN, FAULT, using one shared cycle counter cleared on every state entry.
REQ-016 In RST_PLL: pll_resetb=0 for exactly HOLD_CYCLES cycles, then go to WAIT_LOCK.
REQ-017 In WAIT_LOCK: locked_s=1 -> STABLE; otherwise, after LOCK_TIMEOUT cycles, increment retry count.
REQ-018 On that timeout: retry count reaching MAX_RETRIES -> FAULT; otherwise -> RST_PLL.
REQ-019 In STABLE: locked_s=0 -> WAIT_LOCK (retry count unchanged); STABLE_CYCLES consecutive cycles with locked_s=1 -> RUN, with retry count cleared.
REQ-020 In RUN: locked_s=0 -> RST_PLL and lol_count increments, saturating at 255.
REQ-021 In FAULT: hold pll_resetb=0; leave only on reset or restart.
REQ-022 restart=1 in any state SHALL, next cycle, enter RST_PLL with retry count cleared; restart has priority over every other transition in the same cycle.
REQ-023 Outputs SHALL be registered: pll_resetb=0 in RST_PLL and FAULT, 1 otherwise; sys_reset=0 only in RUN; ready=(state==RUN); fault=(state==FAULT).
REQ-024 Counter widths SHALL hold the largest parameter value with no wrap; all comparisons SHALL be exact-equality on terminal count.
REQ-025 lol_count SHALL NOT be cleared by restart.

Reset
REQ-026 On reset: state=RST_PLL, counter=0, retry count=0, synchronizer flops=0, lol_count=0.
REQ-027 On reset: pll_resetb=0, sys_reset=1, ready=0, fault=0.
REQ-028 Reset asserted mid-operation (including in RUN) SHALL take effect on the next edge and override restart.

Configuration
REQ-029 With macro PLL_SEQ_LOL_COUNT_EN defined: lol_count behaves per REQ-020.
REQ-030 Without PLL_SEQ_LOL_COUNT_EN: no counter register exists, lol_count is constant 0, and all other behaviour is identical.

Verification (defaults)
REQ-031 Release reset with locked=1 constant -> pll_resetb low 4 cycles; ready rises after RST_PLL(4) + 2-cycle sync + STABLE(8); sys_reset falls the same cycle.
REQ-032 locked held 0 -> three 4+16-cycle retry loops, then fault=1, pll_resetb=0, ready=0; restart pulse -> RST_PLL with fault=0.
REQ-033 In STABLE, drop locked for 1 cycle at stable-count 5 -> return to WAIT_LOCK; ready is delayed by a full re-qualification (8 more cycles after locked_s recovers).
REQ-034 In RUN, deassert locked -> ready/sys_reset change 3 cycles later (2 sync + 1 registered); lol_count goes 0->1; 300 such events -> lol_count=255.
REQ-035 Assert restart and reset in the same cycle in RUN -> reset values per REQ-026/REQ-027; lol_count=0.
REQ-036 Build without PLL_SEQ_LOL_COUNT_EN, repeat REQ-034 -> lol_count stays 0 and all other timing is unchanged.
